// File: rtl/spi_slave_shift_if.sv
// spi_slave_shift_if: local-side byte handshake of the SPI responder.
// TX one-entry buffer write port plus RX valid/ack/overflow port.
`timescale 1ns/1ps
interface spi_slave_shift_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_load_i;
    logic              tx_ready_o;
    logic              tx_underrun_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              rx_ack_i;
    logic              rx_ovf_o;

    modport slave (
        input  tx_data_i,
        input  tx_load_i,
        input  rx_ack_i,
        output tx_ready_o,
        output tx_underrun_o,
        output rx_data_o,
        output rx_valid_o,
        output rx_ovf_o
    );

    modport master (
        output tx_data_i,
        output tx_load_i,
        output rx_ack_i,
        input  tx_ready_o,
        input  tx_underrun_o,
        input  rx_data_o,
        input  rx_valid_o,
        input  rx_ovf_o
    );
endinterface

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI responder, all CPOL/CPHA modes, LSB/MSB first.
// Optional SPI_SLV_ECHO_EN: empty TX buffer echoes last rx byte.
`timescale 1ns/1ps
module spi_slave_shift #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic cpol_i,
    input  logic cpha_i,
    input  logic lsbfe_i,
    input  logic sclk_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic miso_o,
    output logic miso_oe_o,
    output logic busy_o,
    spi_slave_shift_if.slave bus
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;

    state_t            r_state;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_lsbfe;
    logic              r_busy;
    logic              r_oe;
    logic [CW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;

    logic [DATA_W-1:0] r_tx_buf;
    logic              r_tx_ready;
    logic              r_tx_udr;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_ovf;

    logic              w_sclk;
    logic              w_ss;
    logic              w_mosi;
    logic              w_edge;
    logic              w_lead;
    logic              w_trail;
    logic              w_run;
    logic              w_enter;
    logic              w_sample;
    logic              w_shift;
    logic              w_done;
    logic              w_consume;
    logic              w_accept;
    logic              w_udr;
    logic [CW-1:0]     w_idx;
    logic [DATA_W-1:0] w_rx_next;
    logic [DATA_W-1:0] w_fill;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_adv;

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_edge  = w_sclk ^ r_sclk_prev;
    assign w_lead  = w_edge & (w_sclk != r_cpol);
    assign w_trail = w_edge & (w_sclk == r_cpol);

    assign w_run    = (r_state == S_ACTIVE) & ~w_ss;
    assign w_enter  = (r_state == S_IDLE) & ~w_ss;
    assign w_sample = w_run & (r_cpha ? w_trail : w_lead);
    assign w_shift  = w_run & (r_cpha ? w_lead : w_trail);
    assign w_done   = w_sample & (r_bit_cnt == LAST);

    // A shift edge with a zero count is the first one after a completion
    // (cpha=0) or the leading edge of a new word (cpha=1).
    assign w_consume = (w_enter & ~cpha_i)
                     | (w_shift & (r_bit_cnt == '0));

    assign w_idx = r_lsbfe ? r_bit_cnt : (LAST - r_bit_cnt);

`ifdef SPI_SLV_ECHO_EN
    assign w_fill = r_rx_data;
    assign w_udr  = 1'b0;
`else
    assign w_fill = '0;
    assign w_udr  = w_consume & r_tx_ready;
`endif

    assign w_word   = r_tx_ready ? w_fill : r_tx_buf;
    assign w_accept = bus.tx_load_i & (r_tx_ready | w_consume);

    assign w_adv = r_lsbfe ? {1'b0, r_tx_shift[DATA_W-1:1]}
                           : {r_tx_shift[DATA_W-2:0], 1'b0};

    // Receive word with the incoming bit merged at its position
    always_comb begin
        w_rx_next        = r_rx_shift;
        w_rx_next[w_idx] = w_mosi;
    end

    // Synchronise the asynchronous SPI pins into pclk
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sclk_prev <= w_sclk;
        end
    end

    // Frame FSM with bit counter and both shifters
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state    <= S_IDLE;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsbfe    <= 1'b0;
            r_busy     <= 1'b0;
            r_oe       <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_ss) begin
                        r_state    <= S_ACTIVE;
                        r_cpol     <= cpol_i;
                        r_cpha     <= cpha_i;
                        r_lsbfe    <= lsbfe_i;
                        r_busy     <= 1'b1;
                        r_oe       <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= cpha_i ? '0 : w_word;
                    end
                end
                S_ACTIVE: begin
                    if (w_ss) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_oe       <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= '0;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_done ? '0 : w_rx_next;
                            r_bit_cnt  <= w_done ? '0
                                        : r_bit_cnt + CW'(1);
                        end
                        if (w_shift) begin
                            r_tx_shift <= (r_bit_cnt == '0) ? w_word
                                                            : w_adv;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One-entry TX buffer; a write in the consume cycle refills it
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_tx_buf   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_udr   <= 1'b0;
        end else begin
            r_tx_udr <= w_udr;
            if (w_accept) begin
                r_tx_buf   <= bus.tx_data_i;
                r_tx_ready <= 1'b0;
            end else if (w_consume) begin
                r_tx_ready <= 1'b1;
            end
        end
    end

    // RX hand-off; a completion beats a same-cycle ack
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            if (w_done) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_rx_ovf   <= r_rx_valid & ~bus.rx_ack_i;
            end else begin
                r_rx_ovf <= 1'b0;
                if (bus.rx_ack_i) begin
                    r_rx_valid <= 1'b0;
                end
            end
        end
    end

    assign miso_o    = r_oe & (r_lsbfe ? r_tx_shift[0]
                                       : r_tx_shift[DATA_W-1]);
    assign miso_oe_o = r_oe;
    assign busy_o    = r_busy;

    assign bus.tx_ready_o    = r_tx_ready;
    assign bus.tx_underrun_o = r_tx_udr;
    assign bus.rx_data_o     = r_rx_data;
    assign bus.rx_valid_o    = r_rx_valid;
    assign bus.rx_ovf_o      = r_rx_ovf;
endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: bit-banged SPI master driving spi_slave_shift.
// Vector table, corner sequences, random frames vs transaction model.
`timescale 1ns/1ps
module tb_spi_slave_shift;
    localparam int H = 8;

    typedef struct {
        logic [1:0] mode;
        logic       lsb;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    logic pclk = 1'b0;
    logic preset_n;
    logic cpol, cpha, lsbfe;
    logic sclk, ss, mosi;
    logic miso, miso_oe, busy;

    spi_slave_shift_if #(.DATA_W(8)) ifc();

    spi_slave_shift #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .cpol_i    (cpol),
        .cpha_i    (cpha),
        .lsbfe_i   (lsbfe),
        .sclk_i    (sclk),
        .ss_i      (ss),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .miso_oe_o (miso_oe),
        .busy_o    (busy),
        .bus       (ifc)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_fail = 0;
    int ovf_seen = 0;
    int udr_seen = 0;
    logic rdy_lead;
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];

    // transaction-level model state
    logic       m_full, m_valid;
    logic [7:0] m_buf, m_last;
    int         e_ovf, e_udr;

    always @(posedge pclk) begin
        if (ifc.rx_ovf_o) ovf_seen <= ovf_seen + 1;
        if (ifc.tx_underrun_o) udr_seen <= udr_seen + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        ifc.tx_data_i = v;
        ifc.tx_load_i = 1'b1;
        cyc(1);
        ifc.tx_load_i = 1'b0;
    endtask

    task automatic ack();
        ifc.rx_ack_i = 1'b1;
        cyc(1);
        ifc.rx_ack_i = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] md, input logic lsb);
        cpol  = md[1];
        cpha  = md[0];
        lsbfe = lsb;
    endtask

    // One SPI frame of nbytes from m_tx; stops after max_edges edges
    task automatic xfer(input int nbytes, input int max_edges);
        logic [7:0] rcv;
        int e;
        int idx;
        bit stop;
        m_rx.delete();
        e = 0;
        stop = 0;
        rcv = '0;
        sclk = cpol;
        cyc(4);
        ss = 1'b0;
        cyc(8);
        for (int b = 0; b < nbytes && !stop; b++) begin
            for (int i = 0; i < 8 && !stop; i++) begin
                idx = lsbfe ? i : 7 - i;
                if (!cpha) mosi = m_tx[b][idx];
                cyc(H);
                sclk = ~cpol;
                e++;
                if (cpha) mosi = m_tx[b][idx];
                else rcv[idx] = miso;
                if (e >= max_edges) stop = 1;
                else begin
                    cyc(H);
                    if (b == 0 && i == 0) rdy_lead = ifc.tx_ready_o;
                    sclk = cpol;
                    e++;
                    if (cpha) rcv[idx] = miso;
                    if (e >= max_edges) stop = 1;
                end
                if (i == 7 && !stop) m_rx.push_back(rcv);
            end
        end
        cyc(H);
        ss = 1'b1;
        sclk = cpol;
        cyc(8);
    endtask

    task automatic complete(input logic [7:0] b);
        if (m_valid) e_ovf++;
        m_valid = 1'b1;
        m_last = b;
    endtask

    initial begin
        vec_t vecs[6];
        int o0, u0;
        logic [7:0] exp_q[$];
        logic [7:0] fill, w, v;
        int nb, loads;

        vecs[0] = '{2'd0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{2'd3, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[2] = '{2'd1, 1'b0, 8'h0F, 8'hF0, 8'h0F, 8'hF0};
        vecs[3] = '{2'd2, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96};
        vecs[4] = '{2'd0, 1'b1, 8'h5A, 8'hA5, 8'h5A, 8'hA5};
        vecs[5] = '{2'd2, 1'b0, 8'hE7, 8'h18, 8'hE7, 8'h18};

        preset_n = 1'b0;
        set_mode(2'd0, 1'b0);
        sclk = 1'b0;
        ss = 1'b1;
        mosi = 1'b0;
        ifc.tx_data_i = '0;
        ifc.tx_load_i = 1'b0;
        ifc.rx_ack_i = 1'b0;
        cyc(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_ready", ifc.tx_ready_o, 1);
        chk("rst_udr", ifc.tx_underrun_o, 0);
        chk("rst_rxdata", ifc.rx_data_o, 0);
        chk("rst_valid", ifc.rx_valid_o, 0);
        chk("rst_ovf", ifc.rx_ovf_o, 0);
        chk("rst_busy", busy, 0);
        preset_n = 1'b1;
        cyc(4);
        chk("idle_busy", busy, 0);
        chk("idle_ready", ifc.tx_ready_o, 1);

        // vector table: one byte each way per mode
        foreach (vecs[k]) begin
            set_mode(vecs[k].mode, vecs[k].lsb);
            load(vecs[k].tx);
            m_tx.delete();
            m_tx.push_back(vecs[k].mo);
            xfer(1, 1000);
            chk("vec_nbytes", m_rx.size(), 1);
            chk("vec_miso", m_rx[0], vecs[k].exp_miso);
            chk("vec_rxdata", ifc.rx_data_o, vecs[k].exp_rx);
            chk("vec_valid", ifc.rx_valid_o, 1);
            chk("vec_ready_lead", rdy_lead, 1);
            ack();
            chk("vec_ack", ifc.rx_valid_o, 0);
        end

        // back-to-back with no ack: one overflow
        set_mode(2'd0, 1'b0);
        load(8'h99);
        m_tx.delete();
        m_tx.push_back(8'h11);
        m_tx.push_back(8'h22);
        o0 = ovf_seen;
        xfer(2, 1000);
        chk("b2b_ovf", ovf_seen - o0, 1);
        chk("b2b_rxdata", ifc.rx_data_o, 8'h22);
        chk("b2b_miso0", m_rx[0], 8'h99);
`ifdef SPI_SLV_ECHO_EN
        chk("b2b_miso1", m_rx[1], 8'h11);
`else
        chk("b2b_miso1", m_rx[1], 8'h00);
`endif
        ack();

        // empty TX buffer in mode 1
        set_mode(2'd1, 1'b0);
        m_tx.delete();
        m_tx.push_back(8'h5A);
        xfer(1, 1000);
        ack();
        u0 = udr_seen;
        m_tx.delete();
        m_tx.push_back(8'h33);
        xfer(1, 1000);
`ifdef SPI_SLV_ECHO_EN
        chk("empty_miso", m_rx[0], 8'h5A);
        chk("empty_udr", udr_seen - u0, 0);
`else
        chk("empty_miso", m_rx[0], 8'h00);
        chk("empty_udr", udr_seen - u0, 1);
`endif
        chk("empty_rx", ifc.rx_data_o, 8'h33);
        ack();

        // abort after 5 edges in mode 2, then a full frame
        set_mode(2'd2, 1'b0);
        load(8'h77);
        m_tx.delete();
        m_tx.push_back(8'hFF);
        xfer(1, 5);
        chk("abort_valid", ifc.rx_valid_o, 0);
        chk("abort_oe", miso_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rxdata", ifc.rx_data_o, 8'h33);
        m_tx.delete();
        m_tx.push_back(8'hC3);
        xfer(1, 1000);
        chk("after_rxdata", ifc.rx_data_o, 8'hC3);
        chk("after_valid", ifc.rx_valid_o, 1);
`ifdef SPI_SLV_ECHO_EN
        chk("after_miso", m_rx[0], 8'h33);
`else
        chk("after_miso", m_rx[0], 8'h00);
`endif
        ack();

        // reset in the middle of a frame
        set_mode(2'd0, 1'b0);
        load(8'h3C);
        sclk = 1'b0;
        cyc(4);
        ss = 1'b0;
        cyc(8);
        repeat (3) begin
            sclk = ~sclk;
            cyc(H);
        end
        chk("mid_busy", busy, 1);
        chk("mid_ready", ifc.tx_ready_o, 1);
        load(8'h44);
        chk("mid_loaded", ifc.tx_ready_o, 0);
        preset_n = 1'b0;
        #1;
        chk("mrst_miso", miso, 0);
        chk("mrst_oe", miso_oe, 0);
        chk("mrst_ready", ifc.tx_ready_o, 1);
        chk("mrst_rxdata", ifc.rx_data_o, 0);
        chk("mrst_valid", ifc.rx_valid_o, 0);
        chk("mrst_busy", busy, 0);
        ss = 1'b1;
        sclk = 1'b0;
        cyc(3);
        preset_n = 1'b1;
        cyc(4);

        // random frames against the transaction model
        m_full = 1'b0;
        m_valid = 1'b0;
        m_buf = '0;
        m_last = '0;
        for (int f = 0; f < 40; f++) begin
            set_mode(2'($urandom), 1'($urandom));
            nb = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                load(v);
                if (!m_full) begin
                    m_full = 1'b1;
                    m_buf = v;
                end
            end
            m_tx.delete();
            for (int b = 0; b < nb; b++) m_tx.push_back(8'($urandom));
            exp_q.delete();
            e_ovf = 0;
            e_udr = 0;
            loads = nb + (cpha ? 0 : 1);
            for (int l = 0; l < loads; l++) begin
                if (l > 0) complete(m_tx[l-1]);
`ifdef SPI_SLV_ECHO_EN
                fill = m_last;
`else
                fill = 8'h00;
`endif
                if (m_full) begin
                    w = m_buf;
                    m_full = 1'b0;
                end else begin
                    w = fill;
`ifndef SPI_SLV_ECHO_EN
                    e_udr++;
`endif
                end
                if (l < nb) exp_q.push_back(w);
            end
            if (cpha) complete(m_tx[nb-1]);
            o0 = ovf_seen;
            u0 = udr_seen;
            xfer(nb, 1000);
            chk("rnd_nbytes", m_rx.size(), nb);
            for (int b = 0; b < nb && b < m_rx.size(); b++)
                chk("rnd_miso", m_rx[b], exp_q[b]);
            chk("rnd_rxdata", ifc.rx_data_o, m_last);
            chk("rnd_valid", ifc.rx_valid_o, m_valid);
            chk("rnd_ovf", ovf_seen - o0, e_ovf);
            chk("rnd_udr", udr_seen - u0, e_udr);
            chk("rnd_ready", ifc.tx_ready_o, !m_full);
            if ($urandom_range(0, 1) == 1) begin
                ack();
                m_valid = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
